// File: rtl/ge_prog_sequencer_pkg.sv
// Shared types for the register-program sequencer.
// Ops, instruction word, FSM states and source-select constants.
package ge_seq_pkg;

  localparam int DEF_LANE_W = 16;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    MOV  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    LNOT = 3'd5,
    BNOT = 3'd6,
    RSV  = 3'd7
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] dst;
    logic [2:0] src;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [2:0] SRC_A0 = 3'd4;

endpackage

// File: rtl/ge_prog_sequencer_if.sv
// Host-side bundle of the sequencer: program port, operands, results.
// err exists only when GE_SEQ_ERR_EN is defined.
interface ge_prog_sequencer_if #(
  parameter int LANE_W = 16,
  parameter int PC_W   = 4
);

  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [7:0]        prog_wdata;
  logic [PC_W:0]     prog_len;
  logic              start;
  logic [LANE_W-1:0] a1, a0, b1, b0;
  logic              busy;
  logic              done;
  logic [LANE_W-1:0] y3, y2, y1, y0;
`ifdef GE_SEQ_ERR_EN
  logic              err;
`endif

  modport master (
    output prog_we, prog_addr, prog_wdata,
    output prog_len, start,
    output a1, a0, b1, b0,
    input  busy, done,
    input  y3, y2, y1, y0
`ifdef GE_SEQ_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata,
    input  prog_len, start,
    input  a1, a0, b1, b0,
    output busy, done,
    output y3, y2, y1, y0
`ifdef GE_SEQ_ERR_EN
    , output err
`endif
  );

endinterface

// File: rtl/ge_prog_sequencer_alu.sv
// Single-op datapath: combines the current dst value with the source.
// Reserved op leaves dst untouched.
module ge_seq_alu
  import ge_seq_pkg::*;
#(
  parameter int LANE_W = 16
) (
  input  op_e               op,
  input  logic [LANE_W-1:0] dst_val,
  input  logic [LANE_W-1:0] src_val,
  output logic [LANE_W-1:0] res
);

  // op decode
  always_comb begin
    res = dst_val;
    unique case (op)
      NOP:  res = dst_val;
      MOV:  res = src_val;
      AND:  res = dst_val & src_val;
      OR:   res = dst_val | src_val;
      XOR:  res = dst_val ^ src_val;
      LNOT: res = {{(LANE_W-1){1'b0}}, (src_val == '0)};
      BNOT: res = ~src_val;
      RSV:  res = dst_val;
    endcase
  end

endmodule

// File: rtl/ge_prog_sequencer.sv
// Runs a stored straight-line register program over four operands.
// Optional: GE_SEQ_ERR_EN makes op 7 abort the run and raise err.
module ge_prog_sequencer
  import ge_seq_pkg::*;
#(
  parameter int LANE_W     = DEF_LANE_W,
  parameter int PROG_DEPTH = DEF_DEPTH,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input logic clk,
  input logic rst,
  ge_prog_sequencer_if.slave bus
);

  localparam logic [PC_W:0] LEN_MAX = (PC_W+1)'(PROG_DEPTH);

  instr_t mem [PROG_DEPTH];

  state_e                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [PC_W:0]           len_q, len_d;
  logic [3:0][LANE_W-1:0]  r_q, r_d;
  logic [3:0][LANE_W-1:0]  lat_q, lat_d;
  logic [3:0][LANE_W-1:0]  y_q, y_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef GE_SEQ_ERR_EN
  logic                    err_q, err_d;
`endif

  instr_t            ins;
  logic [LANE_W-1:0] src_val;
  logic [LANE_W-1:0] alu_res;
  logic              last;
  logic              stop;

  assign ins = mem[pc_q];
  assign src_val = (ins.src >= SRC_A0)
                 ? lat_q[ins.src[1:0]]
                 : r_q[ins.src[1:0]];
  assign last = ((len_q - 1'b1) == {1'b0, pc_q});

  ge_seq_alu #(.LANE_W(LANE_W)) u_alu (
    .op      (ins.op),
    .dst_val (r_q[ins.dst]),
    .src_val (src_val),
    .res     (alu_res)
  );

  // program RAM: writable only while idle, never reset
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == IDLE)
      mem[bus.prog_addr] <= instr_t'(bus.prog_wdata);
  end

  // next-state, register file and result staging
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    r_d     = r_q;
    lat_d   = lat_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    stop    = 1'b0;
`ifdef GE_SEQ_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lat_d   = {bus.b1, bus.b0, bus.a1, bus.a0};
          r_d     = {bus.b1, bus.b0, bus.a1, bus.a0};
          pc_d    = '0;
          len_d   = (bus.prog_len > LEN_MAX)
                  ? LEN_MAX : bus.prog_len;
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef GE_SEQ_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        pc_d = '0;
        if (len_q == '0) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          y_d     = r_q;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        r_d[ins.dst] = alu_res;
        stop = last;
`ifdef GE_SEQ_ERR_EN
        if (ins.op == RSV) begin
          stop  = 1'b1;
          err_d = 1'b1;
        end
`endif
        if (stop) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          y_d     = r_d;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
    endcase
  end

  // state registers with asynchronous abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      r_q     <= '0;
      lat_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GE_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      r_q     <= r_d;
      lat_q   <= lat_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GE_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y0   = y_q[0];
  assign bus.y1   = y_q[1];
  assign bus.y2   = y_q[2];
  assign bus.y3   = y_q[3];
`ifdef GE_SEQ_ERR_EN
  assign bus.err  = err_q;
`endif

endmodule

// File: tb/tb_ge_prog_sequencer.sv
// Directed and random checks of ge_prog_sequencer against a program model.
// Error-abort checks are included when GE_SEQ_ERR_EN is defined.
module tb_ge_prog_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ge_prog_sequencer_if #(.LANE_W(16), .PC_W(4)) bus ();

  ge_prog_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] mem [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] yv();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  task automatic wr(int addr, logic [7:0] d);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr[3:0];
    bus.prog_wdata = d;
    mem[addr]      = d;
    tick();
    bus.prog_we    = 1'b0;
  endtask

  // program semantics: run min(len,16) ops over r = {a0,a1,b0,b1}
  task automatic model(input int len,
                       input logic [15:0] a0, a1, b0, b1,
                       output logic [63:0] y, output int lat,
                       output bit e);
    logic [15:0] r [4];
    logic [15:0] l [4];
    logic [15:0] v;
    int n, ran, op, d, s;
    r = '{a0, a1, b0, b1};
    l = '{a0, a1, b0, b1};
    n = (len > 16) ? 16 : len;
    e = 1'b0;
    ran = n;
    for (int i = 0; i < n; i++) begin
      op = int'(mem[i][7:5]);
      d  = int'(mem[i][4:3]);
      s  = int'(mem[i][2:0]);
      v  = (s < 4) ? r[s] : l[s-4];
`ifdef GE_SEQ_ERR_EN
      if (op == 7) begin
        e = 1'b1;
        ran = i + 1;
        break;
      end
`endif
      case (op)
        1: r[d] = v;
        2: r[d] = r[d] & v;
        3: r[d] = r[d] | v;
        4: r[d] = r[d] ^ v;
        5: r[d] = (v == 16'h0) ? 16'h1 : 16'h0;
        6: r[d] = ~v;
        default: ;
      endcase
    end
    lat = ran + 2;
    y = {r[3], r[2], r[1], r[0]};
  endtask

  task automatic run(string tag, int len,
                     logic [15:0] a0, a1, b0, b1,
                     bit disturb, output logic [63:0] got);
    logic [63:0] ey;
    int el, n;
    bit ee;
    model(len, a0, a1, b0, b1, ey, el, ee);
    bus.prog_len = len[4:0];
    bus.a0 = a0; bus.a1 = a1; bus.b0 = b0; bus.b1 = b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    bus.a0 = 16'($urandom); bus.a1 = 16'($urandom);
    bus.b0 = 16'($urandom); bus.b1 = 16'($urandom);
    n = 1;
    chk({tag, " busy_load"}, 64'(bus.busy), 64'd1);
    while (!bus.done && n < 40) begin
      if (disturb && n == 2) begin
        bus.start      = 1'b1;
        bus.prog_len   = 5'd1;
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 4'd0;
        bus.prog_wdata = ~mem[0];
      end
      tick();
      n++;
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
    end
    chk({tag, " latency"}, 64'(n), 64'(el));
    chk({tag, " y"}, yv(), ey);
    chk({tag, " busy_done"}, 64'(bus.busy), 64'd0);
`ifdef GE_SEQ_ERR_EN
    chk({tag, " err"}, 64'(bus.err), 64'(ee));
`endif
    got = yv();
    tick();
    chk({tag, " done_1cyc"}, 64'(bus.done), 64'd0);
    tick();
    chk({tag, " no_2nd_done"}, 64'(bus.done), 64'd0);
    chk({tag, " y_held"}, yv(), ey);
  endtask

  initial begin
    logic [63:0] y, y_ref;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_wdata = '0;
    bus.prog_len = '0;
    bus.start = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;

    tick();
    tick();
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst y", yv(), 64'd0);
`ifdef GE_SEQ_ERR_EN
    chk("rst err", 64'(bus.err), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // 1: mixed program
    wr(0, 8'h83); wr(1, 8'hAB); wr(2, 8'h4C); wr(3, 8'h70);
    run("t1", 4, 16'h00FF, 16'h0000, 16'h1000, 16'h0F0F, 1'b0, y);
    chk("t1 const", y, 64'h0F0F_1FF0_0000_0FF0);

    // 2: empty program
    run("t2", 0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, y);
    chk("t2 const", y, 64'hDEF0_9ABC_5678_1234);

    // 3: BNOT / LNOT on zeros
    wr(0, 8'hC0); wr(1, 8'hAA);
    run("t3", 2, 16'h0000, 16'hAAAA, 16'h0000, 16'h5555, 1'b0, y);
    chk("t3 y01", {32'h0, y[31:0]}, 64'h0000_0001_FFFF);

    // 4: start and prog_we while busy are ignored
    wr(0, 8'h83); wr(1, 8'hAB); wr(2, 8'h4C); wr(3, 8'h70);
    run("t4", 4, 16'h3C5A, 16'h0001, 16'h8001, 16'hF00F, 1'b1, y_ref);
    run("t4b", 4, 16'h3C5A, 16'h0001, 16'h8001, 16'hF00F, 1'b0, y);
    chk("t4 rerun", y, y_ref);

    // write and start in the same idle cycle: run sees the write
    bus.prog_we = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_wdata = 8'h1D;
    mem[0] = 8'h1D;
    run("t4w", 4, 16'h1111, 16'h2222, 16'h4444, 16'h8888, 1'b0, y);

    // 5: reset mid-run
    for (int i = 0; i < 8; i++) wr(i, 8'(8'h24 + i));
    bus.prog_len = 5'd8;
    bus.a0 = 16'hA5A5; bus.a1 = 16'h0F0F;
    bus.b0 = 16'h3333; bus.b1 = 16'hC0C0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5 busy", 64'(bus.busy), 64'd0);
    chk("t5 done", 64'(bus.done), 64'd0);
    chk("t5 y", yv(), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5 no_done", 64'(bus.done), 64'd0);
    end
    run("t5b", 8, 16'hA5A5, 16'h0F0F, 16'h3333, 16'hC0C0, 1'b0, y);

`ifdef GE_SEQ_ERR_EN
    // 6: reserved op aborts
    wr(0, 8'h3C); wr(1, 8'hE0); wr(2, 8'h83); wr(3, 8'h70);
    run("t6", 4, 16'hBEEF, 16'h0001, 16'h0002, 16'h0003, 1'b0, y);
    chk("t6 y", y, 64'hBEEF_0002_0001_BEEF);
    chk("t6 err_hold", 64'(bus.err), 64'd1);
    wr(1, 8'h83);
    run("t6b", 4, 16'hBEEF, 16'h0001, 16'h0002, 16'h0003, 1'b0, y);
`endif

    // random programs, lengths incl. clamp above 16
    for (int k = 0; k < 25; k++) begin
      int len;
      logic [15:0] o [4];
      for (int i = 0; i < 16; i++) wr(i, 8'($urandom));
      len = $urandom_range(0, 31);
      for (int j = 0; j < 4; j++)
        o[j] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run($sformatf("rnd%0d", k), len, o[0], o[1], o[2], o[3], 1'b0, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
